multidigit_counter_7seg: RTL and testbench
==========================================

MULTIDIGIT_COUNTER_7SEG -- requirements
Module: multidigit_counter_7seg

Interface
REQ-001 Parameter DIGITS, default 4, number of counter digits and display positions; legal range 1..8.
REQ-002 Parameter MAX_DIGIT, default 9, highest value of each digit, so each digit counts 0..MAX_DIGIT; legal range 1..15.
REQ-003 Parameter SCAN_DIV, default 50000, FPGA_clk cycles per display scan slot; legal range >=1.
REQ-004 FPGA_clk  in  1  single clock; all state on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 incr  in  1  debounced increment request, level.
REQ-007 decr  in  1  debounced decrement request, level.
REQ-008 load  in  1  synchronous load strobe.
REQ-009 load_value  in  4*DIGITS  digit i on bits [4i+3:4i].
REQ-010 count  out  4*DIGITS  registered counter value, same packing as load_value.
REQ-011 carry  out  1  one-cycle pulse on wrap from all-MAX_DIGIT to all-zero.
REQ-012 borrow  out  1  one-cycle pulse on wrap from all-zero to all-MAX_DIGIT.
REQ-013 LED_segments  out  7  active-low segments gfedcba of the scanned digit.
REQ-014 LED_dot  out  1  active-low decimal point.
REQ-015 LED_en  out  DIGITS  active-low, one-hot digit enables.

Function
REQ-016 incr and decr SHALL each be rising-edge detected against a registered copy, so a held level produces exactly one step, applied at the edge where the 1 is first sampled.
REQ-017 Priority SHALL be: load > (incr and decr edges in the same cycle: no step, no pulse) > incr > decr.
REQ-018 Increment SHALL add 1 to digit 0, and any digit at MAX_DIGIT SHALL wrap to 0 and carry into the next digit.
REQ-019 Increment from all digits at MAX_DIGIT SHALL give all zero and assert carry for exactly one cycle, coincident with the new count.
REQ-020 Decrement SHALL subtract 1 from digit 0, and any digit at 0 SHALL wrap to MAX_DIGIT and borrow from the next digit.
REQ-021 Decrement from all-zero SHALL give all MAX_DIGIT and assert borrow for exactly one cycle.
REQ-022 Load SHALL copy load_value into count on the next edge; any digit above MAX_DIGIT SHALL be clamped to MAX_DIGIT, and no carry or borrow SHALL be produced.
REQ-023 A sticky ovf flag SHALL be set by carry or borrow and cleared by load.
REQ-024 Prescaler SHALL count 0..SCAN_DIV-1, and at its terminal value the scan index SHALL advance 0..DIGITS-1, wrapping to 0.
REQ-025 LED_en, LED_segments and LED_dot SHALL be registered outputs driven one cycle after the scan index and count they reflect.
REQ-026 LED_en bit equal to the scan index SHALL be 0 and all other bits SHALL be 1.
REQ-027 LED_segments SHALL decode the scanned digit, 0-F, with the active-low table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-028 LED_dot SHALL be 0 only when the scan index is 0 and ovf is set; otherwise it SHALL be 1.
REQ-029 A counter step SHALL NOT disturb the prescaler or the scan index.

Reset
REQ-030 While rst=0, the block SHALL hold count=0, carry=0, borrow=0, ovf=0, prescaler=0, scan index=0, LED_en all ones, LED_segments=1111111, LED_dot=1, and edge registers=0.
REQ-031 Reset asserted mid-scan or mid-step SHALL take effect immediately and asynchronously; release SHALL be synchronous to FPGA_clk.
REQ-032 After release, the first edge SHALL drive LED_en with bit 0 low, showing digit 0.

Configuration
REQ-033 With LEADING_ZERO_BLANK_EN defined, slot i>0 SHALL show 1111111 when digit i and all higher digits are 0; digit 0 is never blanked, and LED_en still scans.
REQ-034 Without LEADING_ZERO_BLANK_EN, every slot SHALL show its decoded digit.

Verification (DIGITS=4, MAX_DIGIT=2, SCAN_DIV=4)
REQ-035 Reset, then 3 incr pulses -> count=0x0010; carry=0 throughout.
REQ-036 Load 0x2222, then incr -> count=0x0000, carry high one cycle, dot lit in slot 0 thereafter.
REQ-037 From reset, decr -> count=0x2222 and borrow high one cycle; incr held 20 cycles -> exactly one step, to 0x0000.
REQ-038 Load 0x0F31 -> count=0x0221 with no pulse; incr and decr rising together -> count unchanged.
REQ-039 Observe 32 cycles -> LED_en walks 1110,1101,1011,0111 with 4 cycles each; with LEADING_ZERO_BLANK_EN and count=0x0001, slots 1-3 show 1111111 and slot 0 shows 1111001.
REQ-040 Assert rst mid-scan during a carry pulse -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/multidigit_counter_7seg.sv
// Multi-digit up/down counter (each digit 0..MAX_DIGIT) with multiplexed active-low 7-segment scan.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits in slots above 0.
module multidigit_counter_7seg #(
  parameter int DIGITS    = 4,
  parameter int MAX_DIGIT = 9,
  parameter int SCAN_DIV  = 50000
) (
  input  logic                FPGA_clk,
  input  logic                rst,
  input  logic                incr,
  input  logic                decr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] count,
  output logic                carry,
  output logic                borrow,
  output logic [6:0]          LED_segments,
  output logic                LED_dot,
  output logic [DIGITS-1:0]   LED_en
);

  localparam int CW    = 4 * DIGITS;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0]       DMAX     = 4'(MAX_DIGIT);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  function automatic logic [CW-1:0] clamp_digits(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > DMAX) r[4*i +: 4] = DMAX;
    return r;
  endfunction

  function automatic logic [CW-1:0] inc_digits(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == DMAX) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] dec_digits(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = DMAX;
        else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic all_digits(input logic [CW-1:0] v, input logic [3:0] d);
    logic r;
    r = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] != d) r = 1'b0;
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic             incr_p1, decr_p1;
  logic             incr_edge, decr_edge;
  logic             ovf;
  logic [CW-1:0]    count_nx;
  logic             carry_nx, borrow_nx, ovf_nx;
  logic [PRE_W-1:0] pre;
  logic [IDX_W-1:0] scan_idx;
  logic [3:0]       digit_sel;
  logic             blank;
  logic [DIGITS-1:0] en_nx;
  logic [6:0]       seg_nx;
  logic             dot_nx;

  assign incr_edge = incr & ~incr_p1;
  assign decr_edge = decr & ~decr_p1;

  // Stage 0: step selection (simultaneous incr/decr edges cancel)
  always_comb begin
    count_nx  = count;
    carry_nx  = 1'b0;
    borrow_nx = 1'b0;
    ovf_nx    = ovf;
    if (load) begin
      count_nx = clamp_digits(load_value);
      ovf_nx   = 1'b0;
    end else if (incr_edge && !decr_edge) begin
      count_nx = inc_digits(count);
      carry_nx = all_digits(count, DMAX);
      ovf_nx   = ovf | carry_nx;
    end else if (decr_edge && !incr_edge) begin
      count_nx  = dec_digits(count);
      borrow_nx = all_digits(count, 4'd0);
      ovf_nx    = ovf | borrow_nx;
    end
  end

  always_ff @(posedge FPGA_clk or negedge rst) begin
    if (!rst) begin
      incr_p1 <= 1'b0;
      decr_p1 <= 1'b0;
      count   <= '0;
      carry   <= 1'b0;
      borrow  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      incr_p1 <= incr;
      decr_p1 <= decr;
      count   <= count_nx;
      carry   <= carry_nx;
      borrow  <= borrow_nx;
      ovf     <= ovf_nx;
    end
  end

  // Stage 1: scan timing, independent of counter steps
  always_ff @(posedge FPGA_clk or negedge rst) begin
    if (!rst) begin
      pre      <= '0;
      scan_idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre      <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  always_comb begin
    digit_sel = 4'd0;
    en_nx     = '1;
    blank     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == scan_idx) begin
        digit_sel = count[4*i +: 4];
        en_nx[i]  = 1'b0;
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic zero_above;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
        zero_above = zero_above && (count[4*i +: 4] == 4'd0);
        if ((IDX_W'(i) == scan_idx) && zero_above) blank = 1'b1;
      end
    end
`endif
    seg_nx = blank ? 7'b1111111 : seg_decode(digit_sel);
    dot_nx = !((scan_idx == '0) && ovf);
  end

  // Stage 2: registered display drive
  always_ff @(posedge FPGA_clk or negedge rst) begin
    if (!rst) begin
      LED_en       <= '1;
      LED_segments <= 7'b1111111;
      LED_dot      <= 1'b1;
    end else begin
      LED_en       <= en_nx;
      LED_segments <= seg_nx;
      LED_dot      <= dot_nx;
    end
  end

endmodule

// File: tb/tb_multidigit_counter_7seg.sv
// Randomized self-checking bench for multidigit_counter_7seg (DIGITS=4, MAX_DIGIT=2, SCAN_DIV=4).
module tb_multidigit_counter_7seg;
  localparam int DIGITS    = 4;
  localparam int MAX_DIGIT = 2;
  localparam int SCAN_DIV  = 4;
  localparam int BASE      = MAX_DIGIT + 1;
  localparam int NVAL      = BASE ** DIGITS;

  logic        FPGA_clk = 1'b0;
  logic        rst = 1'b0;
  logic        incr = 1'b0, decr = 1'b0, load = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] count;
  logic        carry, borrow, LED_dot;
  logic [6:0]  LED_segments;
  logic [3:0]  LED_en;

  multidigit_counter_7seg #(.DIGITS(DIGITS), .MAX_DIGIT(MAX_DIGIT), .SCAN_DIV(SCAN_DIV)) dut (
    .FPGA_clk(FPGA_clk), .rst(rst), .incr(incr), .decr(decr), .load(load),
    .load_value(load_value), .count(count), .carry(carry), .borrow(borrow),
    .LED_segments(LED_segments), .LED_dot(LED_dot), .LED_en(LED_en));

  always #5 FPGA_clk = ~FPGA_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;   6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;   10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;  14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic int digit_of(input int v, input int i);
    return (v / (BASE ** i)) % BASE;
  endfunction

  function automatic logic [15:0] pack(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'(digit_of(v, i));
    return r;
  endfunction

  function automatic int val_of_load(input logic [15:0] lv);
    int s, d;
    s = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > MAX_DIGIT) d = MAX_DIGIT;
      s += d * (BASE ** i);
    end
    return s;
  endfunction

  // Behavioural model: the counter as a single integer modulo BASE**DIGITS
  int         m_val = 0, m_t = 0, m_idx = 0;
  logic       m_carry = 0, m_borrow = 0, m_ovf = 0, m_pi = 0, m_pd = 0, ie, de;
  logic [3:0] e_en = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dot = 1'b1;

  always @(posedge FPGA_clk) begin
    if (!rst) begin
      m_val = 0; m_t = 0; m_carry = 0; m_borrow = 0; m_ovf = 0; m_pi = 0; m_pd = 0;
      e_en = 4'hF; e_seg = 7'h7F; e_dot = 1'b1;
    end else begin
      m_idx = (m_t / SCAN_DIV) % DIGITS;
      e_en  = ~(4'(1) << m_idx);
      e_seg = seg_of(digit_of(m_val, m_idx));
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx > 0 && (m_val / (BASE ** m_idx)) == 0) e_seg = 7'h7F;
`endif
      e_dot = !(m_idx == 0 && m_ovf);
      m_t++;
      ie = incr && !m_pi;
      de = decr && !m_pd;
      m_pi = incr;
      m_pd = decr;
      m_carry = 0;
      m_borrow = 0;
      if (load) begin
        m_val = val_of_load(load_value);
        m_ovf = 0;
      end else if (ie && !de) begin
        m_carry = (m_val == NVAL - 1);
        m_val = (m_val + 1) % NVAL;
        if (m_carry) m_ovf = 1;
      end else if (de && !ie) begin
        m_borrow = (m_val == 0);
        m_val = (m_val + NVAL - 1) % NVAL;
        if (m_borrow) m_ovf = 1;
      end
    end
    #1;
    check("count", 32'(count), 32'(pack(m_val)));
    check("carry", 32'(carry), 32'(m_carry));
    check("borrow", 32'(borrow), 32'(m_borrow));
    check("LED_en", 32'(LED_en), 32'(e_en));
    check("LED_segments", 32'(LED_segments), 32'(e_seg));
    check("LED_dot", 32'(LED_dot), 32'(e_dot));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge FPGA_clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load_value = v; load = 1'b1; tick(1); load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; tick(2); rst = 1'b1; tick(1);
  endtask

  int seen [4];
  int bad_seg, waited;
  logic [6:0] want;

  initial begin
    tick(3);
    check("rst_count", 32'(count), 32'h0);
    check("rst_LED_en", 32'(LED_en), 32'hF);
    check("rst_segments", 32'(LED_segments), 32'h7F);
    check("rst_dot", 32'(LED_dot), 32'h1);
    rst = 1'b1;
    tick(1);
    check("first_scan_en", 32'(LED_en), 32'hE);

    // Three increments in base 3
    repeat (3) begin incr = 1'b1; tick(1); incr = 1'b0; tick(1); end
    check("three_incr", 32'(count), 32'h0010);

    // Wrap up from all-max
    do_load(16'h2222);
    incr = 1'b1; tick(1);
    check("wrap_count", 32'(count), 32'h0000);
    check("carry_pulse", 32'(carry), 32'h1);
    incr = 1'b0; tick(1);
    check("carry_drop", 32'(carry), 32'h0);
    waited = 0;
    while (LED_en != 4'b1110 && waited < 20) begin tick(1); waited++; end
    check("dot_wait", 32'(waited < 20), 32'h1);
    check("dot_lit", 32'(LED_dot), 32'h0);

    // Wrap down from zero, then a held level makes one step
    do_reset();
    decr = 1'b1; tick(1);
    check("borrow_count", 32'(count), 32'h2222);
    check("borrow_pulse", 32'(borrow), 32'h1);
    decr = 1'b0; tick(1);
    check("borrow_drop", 32'(borrow), 32'h0);
    incr = 1'b1; tick(20);
    check("held_incr", 32'(count), 32'h0000);
    incr = 1'b0; tick(1);

    // Clamped load, then cancelling edges
    do_load(16'h0F31);
    check("clamp_load", 32'(count), 32'h0221);
    check("load_no_carry", 32'(carry | borrow), 32'h0);
    incr = 1'b1; decr = 1'b1; tick(1);
    check("both_edges", 32'(count), 32'h0221);
    incr = 1'b0; decr = 1'b0; tick(1);

    // Scan walk and per-slot segments with count=0x0001
    do_load(16'h0001);
    tick(1);
    for (int k = 0; k < 4; k++) seen[k] = 0;
    bad_seg = 0;
    for (int c = 0; c < 32; c++) begin
      for (int k = 0; k < 4; k++) if (LED_en == ~(4'(1) << k)) seen[k]++;
`ifdef LEADING_ZERO_BLANK_EN
      want = (LED_en == 4'b1110) ? 7'b1111001 : 7'b1111111;
`else
      want = (LED_en == 4'b1110) ? 7'b1111001 : 7'b1000000;
`endif
      if (LED_segments != want) bad_seg++;
      tick(1);
    end
    for (int k = 0; k < 4; k++) check("scan_slot_count", 32'(seen[k]), 32'd8);
    check("slot_segments", 32'(bad_seg), 32'd0);

    // Asynchronous reset landing on a carry pulse
    do_load(16'h2222);
    incr = 1'b1;
    @(posedge FPGA_clk);
    #3 rst = 1'b0;
    #1;
    check("async_count", 32'(count), 32'h0);
    check("async_carry", 32'(carry), 32'h0);
    check("async_en", 32'(LED_en), 32'hF);
    check("async_seg", 32'(LED_segments), 32'h7F);
    check("async_dot", 32'(LED_dot), 32'h1);
    incr = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      incr = ($urandom_range(0, 2) == 0);
      decr = ($urandom_range(0, 2) == 0);
      load = ($urandom_range(0, 15) == 0);
      load_value = 16'($urandom);
      rst = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    rst = 1'b1; incr = 1'b0; decr = 1'b0; load = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
